// File: rtl/pong_score_ctrl.sv
// Pong match controller: owns scores, serve delay and win detection around the rally SM.
// Ports: clk/rst_n; btn_start, point_1, point_2 in; sm_rst, start, gameover,
//        score_1, score_2, winner, state_out out (all registered).
// Latency: input edges are registered twice, so a level rising before edge N acts at edge N+1.
module pong_score_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       point_1,
  input  logic       point_2,
  output logic       sm_rst,
  output logic       start,
  output logic       gameover,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic [1:0] winner,
  output logic [1:0] state_out
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SERVE = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_LAST = 16'(SERVE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  score_1_q, score_1_d;
  logic [3:0]  score_2_q, score_2_d;
  logic [1:0]  winner_q, winner_d;
  logic        gameover_q, gameover_d;
  logic        start_q, start_d;
  logic        sm_rst_q, sm_rst_d;

  // Two-stage capture per input: *_cur_q is the sampled level, *_prev_q the one before it.
  logic btn_cur_q, btn_prev_q;
  logic p1_cur_q, p1_prev_q;
  logic p2_cur_q, p2_prev_q;

  logic btn_ev, p1_ev, p2_ev;
  logic [3:0] score_1_inc, score_2_inc;

  assign btn_ev = btn_cur_q & ~btn_prev_q;
  assign p1_ev  = p1_cur_q & ~p1_prev_q;
  assign p2_ev  = p2_cur_q & ~p2_prev_q;

  assign score_1_inc = score_1_q + 4'd1;
  assign score_2_inc = score_2_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    score_1_d  = score_1_q;
    score_2_d  = score_2_q;
    winner_d   = winner_q;
    gameover_d = gameover_q;
    start_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_ev) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (cnt_q == SERVE_LAST) begin
          state_d = ST_PLAY;
          start_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (p1_ev && p2_ev) begin
          // Simultaneous points void the rally.
          state_d = ST_SERVE;
        end else if (p1_ev) begin
          score_1_d = score_1_inc;
          if (score_1_inc == WIN) begin
            state_d    = ST_OVER;
            winner_d   = 2'b01;
            gameover_d = 1'b1;
          end else begin
            state_d = ST_SERVE;
          end
        end else if (p2_ev) begin
          score_2_d = score_2_inc;
          if (score_2_inc == WIN) begin
            state_d    = ST_OVER;
            winner_d   = 2'b10;
            gameover_d = 1'b1;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      ST_OVER: begin
        if (btn_ev) begin
          state_d    = ST_SERVE;
          score_1_d  = 4'd0;
          score_2_d  = 4'd0;
          winner_d   = 2'b00;
          gameover_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter reads 0 on the first SERVE cycle, so SERVE lasts exactly SERVE_CYCLES.
    if (state_q != ST_SERVE) cnt_d = 16'd0;
    else                     cnt_d = cnt_q + 16'd1;

    // Reset the rally SM throughout IDLE and for one cycle whenever a rally ends
    // (SERVE or OVER entry); leave it running otherwise so it can see gameover/start.
    sm_rst_d = (state_d == ST_IDLE) ||
               ((state_d != state_q) && ((state_d == ST_SERVE) || (state_d == ST_OVER)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      score_1_q  <= 4'd0;
      score_2_q  <= 4'd0;
      winner_q   <= 2'b00;
      gameover_q <= 1'b0;
      start_q    <= 1'b0;
      sm_rst_q   <= 1'b1;
      btn_cur_q  <= 1'b0;
      btn_prev_q <= 1'b0;
      p1_cur_q   <= 1'b0;
      p1_prev_q  <= 1'b0;
      p2_cur_q   <= 1'b0;
      p2_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      score_1_q  <= score_1_d;
      score_2_q  <= score_2_d;
      winner_q   <= winner_d;
      gameover_q <= gameover_d;
      start_q    <= start_d;
      sm_rst_q   <= sm_rst_d;
      btn_cur_q  <= btn_start;
      btn_prev_q <= btn_cur_q;
      p1_cur_q   <= point_1;
      p1_prev_q  <= p1_cur_q;
      p2_cur_q   <= point_2;
      p2_prev_q  <= p2_cur_q;
    end
  end

  assign sm_rst    = sm_rst_q;
  assign start     = start_q;
  assign gameover  = gameover_q;
  assign score_1   = score_1_q;
  assign score_2   = score_2_q;
  assign winner    = winner_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
module tb_pong_score_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       point_1 = 1'b0;
  logic       point_2 = 1'b0;
  logic       sm_rst, start, gameover;
  logic [3:0] score_1, score_2;
  logic [1:0] winner, state_out;

  int total = 0;
  int bad   = 0;

  pong_score_ctrl #(.WIN_SCORE(3), .SERVE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start),
    .point_1(point_1), .point_2(point_2),
    .sm_rst(sm_rst), .start(start), .gameover(gameover),
    .score_1(score_1), .score_2(score_2), .winner(winner), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle flag pulse; leaves time 1 after the edge where the controller reacts.
  task automatic pulse_points(input logic a, input logic b);
    point_1 = a; point_2 = b;
    tick();
    point_1 = 1'b0; point_2 = 1'b0;
    tick();
  endtask

  task automatic pulse_btn();
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (state_out !== 2'b00) begin bad++; $display("FAIL rst_state got=%b want=00", state_out); end
    total++; if (sm_rst !== 1'b1) begin bad++; $display("FAIL rst_sm_rst got=%b want=1", sm_rst); end
    total++; if ({start, gameover} !== 2'b00) begin bad++; $display("FAIL rst_start_go got=%b want=00", {start, gameover}); end
    total++; if ({score_1, score_2, winner} !== 10'd0) begin bad++; $display("FAIL rst_scores got=%h want=0", {score_1, score_2, winner}); end
    rst_n = 1'b1;
    tick(); tick();
    total++; if ({state_out, sm_rst} !== 3'b001) begin bad++; $display("FAIL idle_hold got=%b want=001", {state_out, sm_rst}); end
  endtask

  task automatic test_serve();
    pulse_btn();
    total++; if (state_out !== 2'b01) begin bad++; $display("FAIL serve_entry got=%b want=01", state_out); end
    total++; if (sm_rst !== 1'b1) begin bad++; $display("FAIL serve_sm_rst_entry got=%b want=1", sm_rst); end
    tick();
    total++; if ({sm_rst, start} !== 2'b00) begin bad++; $display("FAIL serve_sm_rst_fall got=%b want=00", {sm_rst, start}); end
    tick(); tick();
    total++; if ({state_out, start} !== 3'b010) begin bad++; $display("FAIL serve_early_start got=%b want=010", {state_out, start}); end
    tick();
    total++; if ({state_out, start} !== 3'b101) begin bad++; $display("FAIL serve_start got=%b want=101", {state_out, start}); end
    tick();
    total++; if ({state_out, start} !== 3'b100) begin bad++; $display("FAIL serve_start_once got=%b want=100", {state_out, start}); end
  endtask

  task automatic test_point_hold();
    point_1 = 1'b1;
    tick(); tick();
    total++; if ({score_1, score_2} !== 8'h10) begin bad++; $display("FAIL hold_score got=%h want=10", {score_1, score_2}); end
    total++; if ({state_out, sm_rst} !== 3'b011) begin bad++; $display("FAIL hold_state got=%b want=011", {state_out, sm_rst}); end
    tick();
    total++; if (sm_rst !== 1'b0) begin bad++; $display("FAIL hold_sm_rst_pulse got=%b want=0", sm_rst); end
    tick(); tick();
    point_1 = 1'b0;
    tick();
    total++; if ({state_out, start} !== 3'b101) begin bad++; $display("FAIL hold_restart got=%b want=101", {state_out, start}); end
    tick(); tick();
    total++; if ({score_1, state_out} !== 6'b0001_10) begin bad++; $display("FAIL hold_single_inc got=%b want=000110", {score_1, state_out}); end
  endtask

  task automatic test_void_rally();
    pulse_points(1'b1, 1'b1);
    total++; if ({score_1, score_2} !== 8'h10) begin bad++; $display("FAIL void_scores got=%h want=10", {score_1, score_2}); end
    total++; if (state_out !== 2'b01) begin bad++; $display("FAIL void_state got=%b want=01", state_out); end
    tick(); tick(); tick();
    total++; if (start !== 1'b0) begin bad++; $display("FAIL void_early_start got=%b want=0", start); end
    tick();
    total++; if ({state_out, start} !== 3'b101) begin bad++; $display("FAIL void_start got=%b want=101", {state_out, start}); end
  endtask

  task automatic test_win();
    pulse_points(1'b0, 1'b1);
    total++; if ({score_2, state_out} !== 6'b0001_01) begin bad++; $display("FAIL win_p2_1 got=%b want=000101", {score_2, state_out}); end
    repeat (4) tick();
    pulse_points(1'b0, 1'b1);
    total++; if ({score_2, state_out} !== 6'b0010_01) begin bad++; $display("FAIL win_p2_2 got=%b want=001001", {score_2, state_out}); end
    repeat (4) tick();
    pulse_points(1'b0, 1'b1);
    total++; if ({score_1, score_2} !== 8'h13) begin bad++; $display("FAIL win_scores got=%h want=13", {score_1, score_2}); end
    total++; if ({state_out, winner, gameover} !== 5'b11_10_1) begin bad++; $display("FAIL win_over got=%b want=11101", {state_out, winner, gameover}); end
    tick();
    total++; if (sm_rst !== 1'b0) begin bad++; $display("FAIL win_sm_rst got=%b want=0", sm_rst); end
    pulse_points(1'b1, 1'b0);
    pulse_points(1'b0, 1'b1);
    total++; if ({score_1, score_2, state_out, winner} !== 12'b0001_0011_11_10) begin bad++; $display("FAIL win_ignore got=%b want=000100111110", {score_1, score_2, state_out, winner}); end
  endtask

  task automatic test_restart();
    pulse_btn();
    total++; if ({score_1, score_2, winner, gameover} !== 11'd0) begin bad++; $display("FAIL restart_clear got=%b want=0", {score_1, score_2, winner, gameover}); end
    total++; if ({state_out, sm_rst} !== 3'b011) begin bad++; $display("FAIL restart_state got=%b want=011", {state_out, sm_rst}); end
    repeat (4) tick();
    total++; if ({state_out, start} !== 3'b101) begin bad++; $display("FAIL restart_start got=%b want=101", {state_out, start}); end
  endtask

  task automatic test_async_reset();
    logic saw_start;
    saw_start = 1'b0;
    pulse_points(1'b1, 1'b0);
    repeat (4) tick();
    pulse_points(1'b1, 1'b0);
    repeat (4) tick();
    pulse_points(1'b0, 1'b1);
    tick();
    total++; if ({score_1, score_2, state_out} !== 10'b0010_0001_01) begin bad++; $display("FAIL ar_pre got=%b want=0010000101", {score_1, score_2, state_out}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({state_out, sm_rst, start, gameover} !== 5'b00100) begin bad++; $display("FAIL ar_ctrl got=%b want=00100", {state_out, sm_rst, start, gameover}); end
    total++; if ({score_1, score_2, winner} !== 10'd0) begin bad++; $display("FAIL ar_scores got=%h want=0", {score_1, score_2, winner}); end
    #10 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (start === 1'b1) saw_start = 1'b1;
    end
    total++; if ({saw_start, state_out} !== 3'b000) begin bad++; $display("FAIL ar_no_start got=%b want=000", {saw_start, state_out}); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point_hold();
    test_void_rally();
    test_win();
    test_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_score_ctrl.md
# pong_score_ctrl

Match controller that sits on the far side of the pong game state machine: it consumes the state machine's `point_1`/`point_2` flags and drives its `start`, `gameover` and round-reset inputs. It owns the score registers, serve delay and win detection, so the game state machine only plays single rallies. Score and winner outputs feed the display logic.

## Interface
Parameters:
- `WIN_SCORE`, 7: score that ends the match; legal range 1..15.
- `SERVE_CYCLES`, 16: length of the serve delay in clocks; legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_start`  in  1  debounced, synchronous start/restart button level.
- `point_1`  in  1  game SM flag: player 1 scored. Level, sticky until the SM is reset.
- `point_2`  in  1  game SM flag: player 2 scored. Level, sticky until the SM is reset.
- `sm_rst`  out  1  active-high synchronous reset to the game SM.
- `start`  out  1  one-cycle launch pulse to the game SM.
- `gameover`  out  1  match finished; level.
- `score_1`  out  4  player 1 score.
- `score_2`  out  4  player 2 score.
- `winner`  out  2  00 = none, 01 = player 1, 10 = player 2.
- `state_out`  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 OVER.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - `sm_rst` = 1
  - `start` = 0, `gameover` = 0
  - `score_1` = `score_2` = 0
  - `winner` = 00
  - serve counter = 0
  - edge-detect registers = 0
- Edge detection: `btn_start`, `point_1` and `point_2` are each registered every cycle in every state. An event is a rising edge: current 1, previous 0.

State machine:
- **IDLE**
  - `sm_rst` = 1; scores hold 0.
  - On a `btn_start` rising edge: go to SERVE.
- **SERVE**
  - `sm_rst` = 1 on the entry cycle only, 0 afterwards.
  - Counter clears on entry and increments each cycle.
  - When the counter equals `SERVE_CYCLES`-1: go to PLAY and assert `start` for exactly the first PLAY cycle.
  - Point edges and `btn_start` are ignored.
- **PLAY**, on a point edge:
  - Point edge on exactly one flag: increment that player's score.
    - New score == `WIN_SCORE`: go to OVER, set `winner`, set `gameover` = 1.
    - Otherwise: go to SERVE.
  - Point edges on both flags in the same cycle: the rally is void. Scores are unchanged; go to SERVE.
  - `btn_start` is ignored.
- **OVER**
  - `gameover` = 1 and scores/winner are held.
  - `sm_rst` = 0, so the SM sees `gameover` and returns to init.
  - On a `btn_start` rising edge: clear scores, `winner` and `gameover`; go to SERVE.
- Scores never exceed `WIN_SCORE`; the increment is unsigned 4-bit.
- An asserted `rst_n` at any time returns immediately to the reset values, including mid-serve and mid-rally.

## Timing
- Point-edge response:
  - Point edge sampled at edge N: score, state (SERVE or OVER) and `sm_rst` = 1 all update at edge N+1.
  - `point_x` drops no earlier than N+2, after the SM's synchronous reset.
  - The next point edge is detected only after the flag has been low for at least one cycle.
- Serve duration: exactly `SERVE_CYCLES` cycles in SERVE, then `start` high for one cycle.
  - `sm_rst` falls at least one cycle before `start` rises (guaranteed by `SERVE_CYCLES` ≥ 2).
- `btn_start` edge → SERVE: one cycle of latency.
- No back-pressure and no handshake. The SM must sample `start` in its init state; `start` is never re-issued within one SERVE.

## Test plan
Parameters `WIN_SCORE`=3, `SERVE_CYCLES`=4.
1. Release `rst_n`, pulse `btn_start` → `state_out` 00→01 one cycle later; `sm_rst` high through IDLE plus 1 SERVE cycle; `start` pulses once, exactly 4 cycles after SERVE entry; `state_out`=10.
2. In PLAY, raise and hold `point_1` for 5 cycles → `score_1`=1 next cycle, state SERVE, `sm_rst` 1-cycle pulse; only one increment despite the held level.
3. Raise `point_1` and `point_2` in the same cycle in PLAY → scores unchanged, state SERVE, `start` re-issued after 4 cycles.
4. Three single `point_2` events across rallies → `score_2`=3, `winner`=10, `gameover`=1, `state_out`=11; further point edges are ignored.
5. In OVER, pulse `btn_start` → scores 0, `winner` 00, `gameover` 0, SERVE, then `start` after 4 cycles.
6. Drive `rst_n` low mid-SERVE with score 2–1 → all outputs return to reset values asynchronously; no `start` pulse follows.
